smc_seq: RTL and testbench

SMC_SEQ -- requirements
Module: smc_seq

---
 rtl/smc_pkg.sv | 27 ++
 rtl/smc_eval.sv | 43 ++++
 rtl/smc_seq.sv | 121 ++++++++++++
 tb/tb_smc_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// Shared types and constants for the six-transistor evaluate/sort/weight sequencer.
package smc_pkg;

  localparam int unsigned IN_W      = 3;
  localparam int unsigned VAL_W     = 7;
  localparam int unsigned OUT_W     = 10;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned NUM_BEATS = 6;
  localparam int unsigned CNT_W     = 3;

  localparam int unsigned MODE_CUR   = 0;
  localparam int unsigned MODE_LARGE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [IN_W-1:0] w;
    logic [IN_W-1:0] vgs;
    logic [IN_W-1:0] vds;
  } beat_t;

endpackage

// File: rtl/smc_eval.sv
// Per-transistor evaluation: drain current or transconductance, divided by 3 (truncating).
module smc_eval
  import smc_pkg::*;
(
  input  logic [IN_W-1:0]  i_w,
  input  logic [IN_W-1:0]  i_vgs,
  input  logic [IN_W-1:0]  i_vds,
  input  logic             i_sel_cur,
  output logic [VAL_W-1:0] o_val_c
);

  localparam int unsigned MW = 9;

  logic [MW-1:0] w_ov;
  logic [MW-1:0] w_vds;
  logic [MW-1:0] w_wid;
  logic [MW-1:0] w_shape;
  logic [MW-1:0] w_num;
  logic          w_on;
  logic          w_triode;

  assign w_on     = (i_vgs > IN_W'(1));
  assign w_ov     = MW'(i_vgs) - MW'(1);
  assign w_vds    = MW'(i_vds);
  assign w_wid    = MW'(i_w);
  assign w_triode = (w_ov > w_vds);

  // Per-unit-width factor; every term stays non-negative because ov > V_DS in triode.
  always_comb begin
    w_shape = '0;
    if (i_sel_cur) begin
      if (w_triode) w_shape = MW'(2) * w_ov * w_vds - w_vds * w_vds;
      else          w_shape = w_ov * w_ov;
    end else begin
      if (w_triode) w_shape = MW'(2) * w_vds;
      else          w_shape = MW'(2) * w_ov;
    end
  end

  assign w_num   = w_wid * w_shape;
  assign o_val_c = w_on ? VAL_W'(w_num / MW'(3)) : '0;

endmodule

// File: rtl/smc_seq.sv
// Collects six transistor beats, evaluates, sorts descending and outputs a weighted average.
module smc_seq
  import smc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [MODE_W-1:0] mode,
  input  logic [IN_W-1:0]   W,
  input  logic [IN_W-1:0]   V_GS,
  input  logic [IN_W-1:0]   V_DS,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_n
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [MODE_W-1:0] r_mode;
  beat_t             r_beats [NUM_BEATS];

  beat_t             w_beat;
  logic [VAL_W-1:0]  w_vals  [NUM_BEATS];
  logic [VAL_W-1:0]  w_srt   [NUM_BEATS];
  logic [VAL_W-1:0]  w_a;
  logic [VAL_W-1:0]  w_b;
  logic [VAL_W-1:0]  w_c;
  logic [OUT_W-1:0]  w_sum;
  logic [OUT_W-1:0]  w_result;

  assign w_beat = '{w: W, vgs: V_GS, vds: V_DS};

  for (genvar g = 0; g < NUM_BEATS; g++) begin : g_eval
    smc_eval u_eval (
      .i_w       (r_beats[g].w),
      .i_vgs     (r_beats[g].vgs),
      .i_vds     (r_beats[g].vds),
      .i_sel_cur (r_mode[MODE_CUR]),
      .o_val_c   (w_vals[g])
    );
  end

  // Descending bubble sort over the six evaluated values.
  always_comb begin
    logic [VAL_W-1:0] tmp;
    tmp   = '0;
    w_srt = w_vals;
    for (int unsigned i = 0; i < NUM_BEATS - 1; i++) begin
      for (int unsigned j = 0; j < NUM_BEATS - 1 - i; j++) begin
        if (w_srt[j] < w_srt[j+1]) begin
          tmp        = w_srt[j];
          w_srt[j]   = w_srt[j+1];
          w_srt[j+1] = tmp;
        end
      end
    end
  end

  assign w_a = r_mode[MODE_LARGE] ? w_srt[0] : w_srt[3];
  assign w_b = r_mode[MODE_LARGE] ? w_srt[1] : w_srt[4];
  assign w_c = r_mode[MODE_LARGE] ? w_srt[2] : w_srt[5];

  always_comb begin
    w_sum    = '0;
    w_result = '0;
    if (r_mode[MODE_CUR]) begin
      w_sum    = OUT_W'(3) * OUT_W'(w_a) + OUT_W'(4) * OUT_W'(w_b) + OUT_W'(5) * OUT_W'(w_c);
      w_result = w_sum / OUT_W'(12);
    end else begin
      w_sum    = OUT_W'(w_a) + OUT_W'(w_b) + OUT_W'(w_c);
      w_result = w_sum / OUT_W'(3);
    end
  end

  // Sequencer with registered strobe/result; out_n defaults to zero every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mode    <= '0;
      out_valid <= 1'b0;
      out_n     <= '0;
      for (int unsigned i = 0; i < NUM_BEATS; i++) r_beats[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      out_n     <= '0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mode     <= mode;
            r_beats[0] <= w_beat;
            r_cnt      <= CNT_W'(1);
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            r_beats[r_cnt] <= w_beat;
            if (r_cnt == CNT_W'(NUM_BEATS - 1)) r_state <= CALC;
            else                                r_cnt   <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt   <= '0;
            r_mode  <= '0;
            r_state <= IDLE;
            for (int unsigned i = 0; i < NUM_BEATS; i++) r_beats[i] <= '0;
          end
        end
        CALC: begin
          out_valid <= 1'b1;
          out_n     <= w_result;
          r_cnt     <= '0;
          r_state   <= OUT;
        end
        OUT: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smc_seq.sv
// Scoreboard bench for smc_seq: directed corner bursts, aborts, resets and random back-to-back bursts.
module tb_smc_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] mode;
  logic [2:0] W;
  logic [2:0] V_GS;
  logic [2:0] V_DS;
  logic       out_valid;
  logic [9:0] out_n;

  typedef struct {
    int n;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;
  int   cyc;
  int   bw[6];
  int   bg[6];
  int   bd[6];

  smc_seq u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .W         (W),
    .V_GS      (V_GS),
    .V_DS      (V_DS),
    .out_valid (out_valid),
    .out_n     (out_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int ev(input int w, input int g, input int d, input bit cur);
    int ov;
    if (g <= 1) return 0;
    ov = g - 1;
    if (ov > d) return cur ? (w * (2 * ov * d - d * d)) / 3 : (2 * w * d) / 3;
    return cur ? (w * ov * ov) / 3 : (2 * w * ov) / 3;
  endfunction

  function automatic int model(input logic [1:0] m);
    int v[6];
    int t;
    int a;
    int b;
    int c;
    for (int i = 0; i < 6; i++) v[i] = ev(bw[i], bg[i], bd[i], m[0]);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5 - i; j++)
        if (v[j] < v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    a = m[1] ? v[0] : v[3];
    b = m[1] ? v[1] : v[4];
    c = m[1] ? v[2] : v[5];
    return m[0] ? (3 * a + 4 * b + 5 * c) / 12 : (a + b + c) / 3;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pop one expectation per strobe, otherwise out_n must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexp_strobe", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("out_n", int'(out_n), e.n);
        check("strobe_cyc", cyc, e.cyc);
      end
    end else begin
      check("n_zero", int'(out_n), 0);
    end
  end

  task automatic set_all(input int w, input int g, input int d);
    for (int i = 0; i < 6; i++) begin
      bw[i] = w; bg[i] = g; bd[i] = d;
    end
  endtask

  // nbeats<6 aborts; rph 1 resets during CALC, 2 during OUT; exp<0 means no strobe expected.
  task automatic burst(input logic [1:0] m, input int exp, input int nbeats,
                       input bit junk, input int rph, input bit rel);
    exp_t e;
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clk); #1;
      if (rel && i == 0) rst_n = 1'b1;
      in_valid = 1'b1;
      mode     = (i == 0) ? m : 2'($urandom);
      W        = 3'(bw[i]);
      V_GS     = 3'(bg[i]);
      V_DS     = 3'(bd[i]);
      if (i == 5 && exp >= 0 && rph == 0) begin
        e.n = exp; e.cyc = cyc + 2;
        sb_q.push_back(e);
      end
    end
    if (rph == 1) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("rst_calc_v", int'(out_valid), 0);
      check("rst_calc_n", int'(out_n), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else if (rph == 2) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_v", int'(out_valid), 1);
      check("pre_rst_n", int'(out_n), exp);
      rst_n = 1'b0;
      #1;
      check("rst_out_v", int'(out_valid), 0);
      check("rst_out_n", int'(out_n), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        @(posedge clk); #1;
        in_valid = junk;
        mode     = 2'($urandom);
        W        = 3'($urandom);
        V_GS     = 3'($urandom);
        V_DS     = 3'($urandom);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] m;
    n_vec    = 0;
    n_err    = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode     = '0;
    W        = '0;
    V_GS     = '0;
    V_DS     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_n_out", int'(out_n), 0);

    set_all(1, 3, 2);
    burst(2'b01, 1, 6, 1'b0, 0, 1'b1);

    set_all(7, 7, 7);
    burst(2'b11, 84, 6, 1'b1, 0, 1'b0);
    burst(2'b00, 28, 6, 1'b0, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      bw[i] = 3; bg[i] = (i < 3) ? 4 : 0; bd[i] = 7;
    end
    burst(2'b10, 6, 6, 1'b0, 0, 1'b0);
    burst(2'b00, 0, 6, 1'b1, 0, 1'b0);

    set_all(6, 5, 2);
    burst(2'b01, 24, 6, 1'b0, 0, 1'b0);
    burst(2'b00, 8, 6, 1'b0, 0, 1'b0);

    set_all(5, 6, 3);
    burst(2'b01, -1, 4, 1'b0, 0, 1'b0);
    burst(2'b01, model(2'b01), 6, 1'b0, 0, 1'b0);

    set_all(7, 7, 7);
    burst(2'b11, -1, 6, 1'b0, 1, 1'b0);
    burst(2'b11, 84, 6, 1'b0, 2, 1'b0);
    set_all(6, 5, 2);
    burst(2'b01, 24, 6, 1'b0, 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 6; i++) begin
        bw[i] = int'($urandom_range(7, 0));
        bg[i] = int'($urandom_range(7, 0));
        bd[i] = int'($urandom_range(7, 0));
      end
      m = 2'(r);
      burst(m, model(m), 6, r[0], 0, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("pending", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
